// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ        = 4;
    localparam int SEL_W        = 2;
    localparam int CNT_W        = 4;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // One-hot vector with only bit 'idx' set.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set bit of i_mask scanning
// i_start, i_start+1, ... modulo 4.
module mux4_rr_pick
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_mask,
    input  logic [SEL_W-1:0] i_start,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]   w_off;

    // Doubling the mask lets a plain part-select perform the rotation.
    assign w_dbl = {i_mask, i_mask};
    assign w_rot = w_dbl[i_start +: N_REQ];

    // Lowest set bit of the rotated mask is the offset from the start point.
    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign o_idx = i_start + w_off;
    assign o_any = |i_mask;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold in front of a 4:1 one-bit mux.
// Drives a one-hot grant, the mux select and a registered, qualified data bit.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_d,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_y,
    output logic             o_valid
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_HOLD - 1);

    arb_state_e       r_state;
    logic [SEL_W-1:0] r_g;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_gnt;
    logic             r_y;
    logic             r_valid;

    arb_state_e       w_state_next;
    logic [SEL_W-1:0] w_g_next;
    logic [SEL_W-1:0] w_ptr_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [N_REQ-1:0] w_pick_mask;
    logic [SEL_W-1:0] w_pick_start;
    logic [SEL_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_data_ok;

    // In IDLE the scan begins at the saved pointer; while granted it begins
    // just past the owner and excludes the owner, so a set result always
    // means "someone else is waiting" (when the owner has dropped its request
    // the exclusion changes nothing).
    assign w_pick_mask  = (r_state == IDLE) ? i_req : (i_req & ~onehot(r_g));
    assign w_pick_start = (r_state == IDLE) ? r_ptr : (r_g + SEL_W'(1));

    mux4_rr_pick u_pick (
        .i_mask  (w_pick_mask),
        .i_start (w_pick_start),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Next-state logic: grant, release with no bubble, rotate at the hold limit.
    always_comb begin
        w_state_next = r_state;
        w_g_next     = r_g;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_next = GRANT;
                    w_g_next     = w_pick_idx;
                    w_cnt_next   = '0;
                end
            end
            GRANT: begin
                if (!i_req[r_g]) begin
                    w_ptr_next = r_g + SEL_W'(1);
                    w_cnt_next = '0;
                    if (w_pick_any) begin
                        w_g_next = w_pick_idx;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if ((r_cnt == CNT_LIMIT) && w_pick_any) begin
                    w_ptr_next = r_g + SEL_W'(1);
                    w_g_next   = w_pick_idx;
                    w_cnt_next = '0;
                end else if (r_cnt != CNT_LIMIT) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Data is qualified by the owner still requesting at the sampling edge.
    assign w_data_ok = (r_state == GRANT) && i_req[r_g];

    // Arbitration state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_g     <= w_g_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Registered output stage: grant vector and the selected data bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt   <= '0;
            r_y     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_gnt   <= (w_state_next == GRANT) ? onehot(w_g_next) : '0;
            r_valid <= w_data_ok;
            r_y     <= w_data_ok & i_d[r_g];
        end
    end

    assign o_gnt   = r_gnt;
    assign o_sel   = r_g;
    assign o_y     = r_y;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a reference-model scoreboard.
module tb_mux4_rr_arbiter;

    localparam int MH = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       y;
        logic       v;
    } exp_t;

    logic       clk;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [3:0] i_d;
    logic [3:0] o_gnt;
    logic [1:0] o_sel;
    logic       o_y;
    logic       o_valid;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];

    // Reference model state
    bit       m_state;
    logic [1:0] m_g;
    logic [1:0] m_ptr;
    int       m_cnt;

    mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_d     (i_d),
        .o_gnt   (o_gnt),
        .o_sel   (o_sel),
        .o_y     (o_y),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [1:0] rr(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        rr = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (mask[idx]) rr = idx;
        end
    endfunction

    task automatic model_reset();
        m_state = 1'b0;
        m_g     = 2'd0;
        m_ptr   = 2'd0;
        m_cnt   = 0;
    endtask

    // Predict outputs after the coming edge and advance the model.
    task automatic model_step(input logic [3:0] req, input logic [3:0] d, output exp_t e);
        logic [1:0] old_g;
        logic [3:0] others;
        logic       nv;
        logic       ny;
        old_g  = m_g;
        nv     = m_state && req[old_g];
        ny     = nv && d[old_g];
        others = req & ~(4'b0001 << old_g);
        if (!m_state) begin
            if (req != 4'b0) begin
                m_state = 1'b1;
                m_g     = rr(req, m_ptr);
                m_cnt   = 0;
            end
        end else if (!req[old_g]) begin
            m_ptr = old_g + 2'd1;
            m_cnt = 0;
            if (req != 4'b0) m_g = rr(req, old_g + 2'd1);
            else             m_state = 1'b0;
        end else if (m_cnt == MH - 1 && others != 4'b0) begin
            m_ptr = old_g + 2'd1;
            m_g   = rr(others, old_g + 2'd1);
            m_cnt = 0;
        end else if (m_cnt < MH - 1) begin
            m_cnt++;
        end
        e.gnt = m_state ? (4'b0001 << m_g) : 4'b0000;
        e.sel = m_g;
        e.y   = ny;
        e.v   = nv;
    endtask

    // One clock: drive, predict, push; then pop and compare after the edge.
    task automatic step(input logic [3:0] req, input logic [3:0] d);
        exp_t e;
        i_req = req;
        i_d   = d;
        model_step(req, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("step req=%b d=%b -> gnt=%b sel=%0d y=%b valid=%b", req, d, o_gnt, o_sel, o_y, o_valid);
        chk("sb_gnt",   o_gnt,            e.gnt);
        chk("sb_sel",   {2'b00, o_sel},   {2'b00, e.sel});
        chk("sb_y",     {3'b000, o_y},    {3'b000, e.y});
        chk("sb_valid", {3'b000, o_valid}, {3'b000, e.v});
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("rst_gnt",   o_gnt,             4'b0000);
        chk("rst_sel",   {2'b00, o_sel},    4'b0000);
        chk("rst_y",     {3'b000, o_y},     4'b0000);
        chk("rst_valid", {3'b000, o_valid}, 4'b0000);
        model_reset();
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] vv;
        logic [3:0] sreq;
        i_rst_n = 1'b0;
        i_req   = 4'b1111;
        i_d     = 4'b1111;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_gnt",   o_gnt,             4'b0000);
        chk("reset_sel",   {2'b00, o_sel},    4'b0000);
        chk("reset_y",     {3'b000, o_y},     4'b0000);
        chk("reset_valid", {3'b000, o_valid}, 4'b0000);
        i_rst_n = 1'b1;

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 4'b0000);
            chk("idle_gnt",   o_gnt,             4'b0000);
            chk("idle_valid", {3'b000, o_valid}, 4'b0000);
        end

        // Single requester held well beyond MAX_HOLD
        step(4'b0100, 4'b0100);
        chk("single_gnt", o_gnt,          4'b0100);
        chk("single_sel", {2'b00, o_sel}, 4'd2);
        step(4'b0100, 4'b0100);
        chk("single_y",     {3'b000, o_y},     4'b0001);
        chk("single_valid", {3'b000, o_valid}, 4'b0001);
        for (int k = 0; k < 12; k++) begin
            step(4'b0100, 4'b0100);
            chk("single_hold", o_gnt, 4'b0100);
        end

        // Release to idle, then pointer persistence: scan from 3 wraps to 0
        step(4'b0000, 4'b0000);
        chk("release_idle", o_gnt, 4'b0000);
        step(4'b0101, 4'b0000);
        chk("ptr_wrap_gnt", o_gnt,          4'b0001);
        chk("ptr_wrap_sel", {2'b00, o_sel}, 4'd0);

        // Full contention from a fresh pointer
        async_reset();
        for (int k = 0; k < 20; k++) begin
            step(4'b1111, 4'b1010);
            chk("contend_gnt", o_gnt, 4'b0001 << ((k / 4) % 4));
            chk("contend_sel", {2'b00, o_sel}, 4'((k / 4) % 4));
        end

        // Early release: owner 0 drops after two granted cycles
        async_reset();
        step(4'b0011, 4'b0011);
        chk("early_first", o_gnt, 4'b0001);
        step(4'b0011, 4'b0011);
        step(4'b0010, 4'b0011);
        chk("early_handoff", o_gnt, 4'b0010);
        step(4'b0010, 4'b0011);
        chk("early_valid", {3'b000, o_valid}, 4'b0001);
        chk("early_y",     {3'b000, o_y},     4'b0001);

        // Exhaustive data path sweep per select value, with a mid-sweep reset
        for (int s = 0; s < 4; s++) begin
            sreq = 4'b0001 << s;
            step(sreq, 4'b0000);
            chk("sweep_gnt", o_gnt, sreq);
            for (int v = 0; v < 16; v++) begin
                if (s == 2 && v == 8) begin
                    async_reset();
                    step(sreq, 4'b0000);
                end
                vv = 4'(v);
                step(sreq, vv);
                chk("sweep_y",     {3'b000, o_y},     {3'b000, vv[s]});
                chk("sweep_valid", {3'b000, o_valid}, 4'b0001);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
